xgs_trig_ctrl: RTL and testbench
================================

XGS_TRIG_CTRL -- requirements
Module: xgs_trig_ctrl

Interface
REQ-001 SHALL have parameter NUM_HW_TRIG, default 4, number of hardware trigger input channels (1..16).
REQ-002 SHALL have parameter DLY_W, default 24, width of the trigger delay counter.
REQ-003 SHALL have parameter DBNC_W, default 8, width of the debounce counter.
REQ-004 SHALL have parameter MISS_W, default 16, width of the missed-trigger counter.
REQ-005 SHALL have port sys_clk  in  1  the only clock; all logic is on its rising edge.
REQ-006 SHALL have port sys_reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port hw_trig  in  NUM_HW_TRIG  asynchronous hardware trigger pins.
REQ-008 SHALL have port sw_trig  in  1  single-cycle software trigger strobe.
REQ-009 SHALL have port grab_en  in  1  grab enable; low aborts and idles the block.
REQ-010 SHALL have port cfg_grab_src  in  2  0=NONE, 1=IMMEDIATE, 2=HW_TRIG, 3=SW_TRIG.
REQ-011 SHALL have port cfg_act  in  3  0=RISING, 1=FALLING, 2=ANY, 3=LEVEL_HI, 4=LEVEL_LO; 5..7 are treated as RISING.
REQ-012 SHALL have port cfg_hw_sel  in  clog2(NUM_HW_TRIG) (min 1)  selected hardware channel; values >= NUM_HW_TRIG select channel 0.
REQ-013 SHALL have port cfg_delay  in  DLY_W  trigger-to-issue delay in cycles.
REQ-014 SHALL have port cfg_debounce  in  DBNC_W  required stable cycles on the selected channel.
REQ-015 SHALL have port sensor_ready  in  1  the sensor can accept a frame trigger.
REQ-016 SHALL have port trig_out  out  1  single-cycle registered frame trigger to the sensor.
REQ-017 SHALL have port busy  out  1  high when the state is not IDLE.
REQ-018 SHALL have port missed_cnt  out  MISS_W  count of rejected edge/SW events, saturating.
REQ-019 SHALL have port missed_clr  in  1  synchronous clear of missed_cnt.

Function
REQ-020 SHALL pass every hw_trig bit through a two-flop synchronizer; only the cfg_hw_sel channel feeds the filter.
REQ-021 SHALL update the filtered level only after the synchronized value has differed from it for cfg_debounce+1 consecutive cycles (0 = one cycle), restarting the count on any bounce or cfg_hw_sel change.
REQ-022 SHALL generate an event per mode: RISING/FALLING/ANY = matching filtered edge; LEVEL_HI/LO = filtered level matches; SW_TRIG = sw_trig; IMMEDIATE = constant 1; NONE = never; all gated by grab_en.
REQ-023 SHALL implement states IDLE, DELAY, ARM.
REQ-024 SHALL, in IDLE on an event, load cnt=cfg_delay and enter DELAY at the next edge.
REQ-025 SHALL, in DELAY, decrement cnt while cnt!=0 and enter ARM when cnt==0; DELAY therefore lasts cfg_delay+1 cycles.
REQ-026 SHALL, in ARM with sensor_ready=1, assert trig_out for exactly the next cycle and return to IDLE; ARM waits indefinitely while sensor_ready=0.
REQ-027 SHALL, for an edge or SW event arriving while not IDLE, increment missed_cnt; saturate at all-ones; missed_clr wins over a simultaneous increment.
REQ-028 SHALL never count level or IMMEDIATE events as missed.
REQ-029 SHALL, on grab_en=0 in any state, return to IDLE at the next edge with no trig_out pulse; a pulse already registered completes.
REQ-030 SHALL sample cfg_delay only when leaving IDLE; other cfg_* changes take effect immediately.

Reset
REQ-031 SHALL, on sys_reset=1, set state=IDLE, trig_out=0, busy=0, missed_cnt=0, cnt=0, synchronizers and filtered level=0, debounce count=0, overriding every other input.

Verification
REQ-032 HW RISING, ch 2, debounce 0, delay 0, sensor_ready=1; hw_trig[2] 0->1 -> trig_out single pulse 6 cycles after the first edge sampling 1.
REQ-033 debounce=3; 2-cycle glitch on the selected channel -> no event; 6-cycle pulse -> exactly one trig_out.
REQ-034 SW_TRIG, delay 10; sw_trig twice 4 cycles apart -> one trig_out 13 cycles after the first strobe, missed_cnt=1.
REQ-035 IMMEDIATE, delay 0, sensor_ready toggling -> one trig_out per ARM/ready cycle, missed_cnt stays 0.
REQ-036 grab_en dropped during DELAY (delay 100) -> IDLE next cycle, no trig_out; sys_reset mid-ARM -> all outputs 0 next cycle.
REQ-037 Saturation: missed_cnt forced to all-ones via MISS_W=2 and 5 rejected events -> reads 3; missed_clr -> 0.

Source files
------------

// File: rtl/xgs_trig_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : xgs_trig_ctrl
// Brief   : Frame-trigger controller: HW/SW/immediate sources, debounce, delay
//           and handshake with the sensor, plus a saturating missed counter.
// Revision: 1.0 - initial release
// ============================================================================
module xgs_trig_ctrl #(
    parameter int NUM_HW_TRIG = 4,
    parameter int DLY_W       = 24,
    parameter int DBNC_W      = 8,
    parameter int MISS_W      = 16
) (
    input  logic                       sys_clk,
    input  logic                       sys_reset,
    input  logic [NUM_HW_TRIG-1:0]     hw_trig,
    input  logic                       sw_trig,
    input  logic                       grab_en,
    input  logic [1:0]                 cfg_grab_src,
    input  logic [2:0]                 cfg_act,
    input  logic [((NUM_HW_TRIG > 1) ? $clog2(NUM_HW_TRIG) : 1)-1:0] cfg_hw_sel,
    input  logic [DLY_W-1:0]           cfg_delay,
    input  logic [DBNC_W-1:0]          cfg_debounce,
    input  logic                       sensor_ready,
    output logic                       trig_out,
    output logic                       busy,
    output logic [MISS_W-1:0]          missed_cnt,
    input  logic                       missed_clr
);

    localparam int C_SEL_W = (NUM_HW_TRIG > 1) ? $clog2(NUM_HW_TRIG) : 1;

    localparam logic [1:0] C_SRC_NONE = 2'd0;
    localparam logic [1:0] C_SRC_IMM  = 2'd1;
    localparam logic [1:0] C_SRC_HW   = 2'd2;
    localparam logic [1:0] C_SRC_SW   = 2'd3;

    localparam logic [2:0] C_ACT_FALL = 3'd1;
    localparam logic [2:0] C_ACT_ANY  = 3'd2;
    localparam logic [2:0] C_ACT_LHI  = 3'd3;
    localparam logic [2:0] C_ACT_LLO  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_ARM   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_HW_TRIG-1:0] sync1_q, sync2_q;
    logic [C_SEL_W-1:0]     sel_prev_q;
    logic [DBNC_W-1:0]      dbnc_cnt_q, dbnc_cnt_d;
    logic                   filt_q, filt_d, filt_prev_q;
    logic                   evt_q, evt_d, evt_edge_q, evt_edge_d;
    logic [DLY_W-1:0]       cnt_q, cnt_d;
    logic                   trig_q, trig_d;
    logic [MISS_W-1:0]      missed_q, missed_d;
    logic                   sel_bit;
    logic                   hw_evt, hw_is_edge;
    logic                   evt_live;

    always_comb begin
        sel_bit = sync2_q[0];
        if (int'(cfg_hw_sel) < NUM_HW_TRIG) begin
            sel_bit = sync2_q[cfg_hw_sel];
        end
    end

    // Debounce: the filtered level follows the selected channel only after it
    // has disagreed for cfg_debounce+1 consecutive cycles.
    always_comb begin
        dbnc_cnt_d = dbnc_cnt_q;
        filt_d     = filt_q;
        if (cfg_hw_sel != sel_prev_q) begin
            dbnc_cnt_d = '0;
        end else if (sel_bit == filt_q) begin
            dbnc_cnt_d = '0;
        end else if (dbnc_cnt_q >= cfg_debounce) begin
            filt_d     = sel_bit;
            dbnc_cnt_d = '0;
        end else begin
            dbnc_cnt_d = dbnc_cnt_q + DBNC_W'(1);
        end
    end

    always_comb begin
        hw_evt     = filt_q & ~filt_prev_q;
        hw_is_edge = 1'b1;
        case (cfg_act)
            C_ACT_FALL: hw_evt = ~filt_q & filt_prev_q;
            C_ACT_ANY:  hw_evt = filt_q ^ filt_prev_q;
            C_ACT_LHI: begin
                hw_evt     = filt_q;
                hw_is_edge = 1'b0;
            end
            C_ACT_LLO: begin
                hw_evt     = ~filt_q;
                hw_is_edge = 1'b0;
            end
            default: hw_evt = filt_q & ~filt_prev_q;
        endcase
    end

    always_comb begin
        evt_d      = 1'b0;
        evt_edge_d = 1'b0;
        case (cfg_grab_src)
            C_SRC_NONE: evt_d = 1'b0;
            C_SRC_IMM:  evt_d = 1'b1;
            C_SRC_HW: begin
                evt_d      = hw_evt;
                evt_edge_d = hw_is_edge;
            end
            C_SRC_SW: begin
                evt_d      = sw_trig;
                evt_edge_d = 1'b1;
            end
            default: evt_d = 1'b0;
        endcase
        evt_d = evt_d & grab_en;
    end

    assign evt_live = evt_q & grab_en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trig_d  = 1'b0;
        if (!grab_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (evt_live) begin
                        cnt_d   = cfg_delay;
                        state_d = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DLY_W'(1);
                    end else begin
                        state_d = ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (sensor_ready) begin
                        trig_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Only edge-type (HW edge or SW strobe) events can be missed; clear wins.
    always_comb begin
        missed_d = missed_q;
        if (missed_clr) begin
            missed_d = '0;
        end else if (evt_live && evt_edge_q && (state_q != ST_IDLE) && (missed_q != '1)) begin
            missed_d = missed_q + MISS_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q     <= ST_IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            sel_prev_q  <= '0;
            dbnc_cnt_q  <= '0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            evt_q       <= 1'b0;
            evt_edge_q  <= 1'b0;
            cnt_q       <= '0;
            trig_q      <= 1'b0;
            missed_q    <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= hw_trig;
            sync2_q     <= sync1_q;
            sel_prev_q  <= cfg_hw_sel;
            dbnc_cnt_q  <= dbnc_cnt_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            evt_q       <= evt_d;
            evt_edge_q  <= evt_edge_d;
            cnt_q       <= cnt_d;
            trig_q      <= trig_d;
            missed_q    <= missed_d;
        end
    end

    assign trig_out   = trig_q;
    assign busy       = (state_q != ST_IDLE);
    assign missed_cnt = missed_q;

endmodule
`default_nettype wire

// File: tb/tb_xgs_trig_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_xgs_trig_ctrl
// Brief   : Directed self-checking bench for xgs_trig_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_xgs_trig_ctrl;

    localparam int NUM_HW_TRIG = 4;
    localparam int DLY_W       = 24;
    localparam int DBNC_W      = 8;
    localparam int MISS_W      = 2;

    localparam logic [1:0] SRC_IMM  = 2'd1;
    localparam logic [1:0] SRC_HW   = 2'd2;
    localparam logic [1:0] SRC_SW   = 2'd3;
    localparam logic [2:0] ACT_RISE = 3'd0;
    localparam logic [2:0] ACT_FALL = 3'd1;

    logic                   sys_clk = 1'b0;
    logic                   sys_reset;
    logic [NUM_HW_TRIG-1:0] hw_trig;
    logic                   sw_trig;
    logic                   grab_en;
    logic [1:0]             cfg_grab_src;
    logic [2:0]             cfg_act;
    logic [1:0]             cfg_hw_sel;
    logic [DLY_W-1:0]       cfg_delay;
    logic [DBNC_W-1:0]      cfg_debounce;
    logic                   sensor_ready;
    logic                   trig_out;
    logic                   busy;
    logic [MISS_W-1:0]      missed_cnt;
    logic                   missed_clr;

    int n_checks = 0;
    int n_errors = 0;

    xgs_trig_ctrl #(
        .NUM_HW_TRIG(NUM_HW_TRIG),
        .DLY_W      (DLY_W),
        .DBNC_W     (DBNC_W),
        .MISS_W     (MISS_W)
    ) u_dut (
        .sys_clk     (sys_clk),
        .sys_reset   (sys_reset),
        .hw_trig     (hw_trig),
        .sw_trig     (sw_trig),
        .grab_en     (grab_en),
        .cfg_grab_src(cfg_grab_src),
        .cfg_act     (cfg_act),
        .cfg_hw_sel  (cfg_hw_sel),
        .cfg_delay   (cfg_delay),
        .cfg_debounce(cfg_debounce),
        .sensor_ready(sensor_ready),
        .trig_out    (trig_out),
        .busy        (busy),
        .missed_cnt  (missed_cnt),
        .missed_clr  (missed_clr)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Idle the block, load configuration, let the filter settle, then enable.
    task automatic setup(input logic [1:0] src, input logic [2:0] act, input logic [1:0] sel,
                         input logic [DLY_W-1:0] dly, input logic [DBNC_W-1:0] db, input logic rdy);
        grab_en      = 1'b0;
        hw_trig      = '0;
        sw_trig      = 1'b0;
        cfg_grab_src = src;
        cfg_act      = act;
        cfg_hw_sel   = sel;
        cfg_delay    = dly;
        cfg_debounce = db;
        sensor_ready = rdy;
        missed_clr   = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        missed_clr   = 1'b0;
        grab_en      = 1'b1;
    endtask

    task automatic test_reset();
        sys_reset = 1'b1;
        hw_trig = '0; sw_trig = 1'b0; grab_en = 1'b0; cfg_grab_src = 2'd0;
        cfg_act = 3'd0; cfg_hw_sel = 2'd0; cfg_delay = '0; cfg_debounce = '0;
        sensor_ready = 1'b0; missed_clr = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (trig_out !== 1'b0 || busy !== 1'b0 || missed_cnt !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_state: got trig=%b busy=%b missed=%0d want 0/0/0", trig_out, busy, missed_cnt);
        end
        sys_reset = 1'b0;
        tick();
    endtask

    task automatic test_hw_rising();
        int pulses;
        setup(SRC_HW, ACT_RISE, 2'd2, '0, '0, 1'b1);
        hw_trig = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (trig_out !== 1'(i == 6) || busy !== 1'(i == 4 || i == 5)) begin
                n_errors++;
                $display("FAIL hw_rise cycle %0d: got trig=%b busy=%b want trig=%b busy=%b",
                         i, trig_out, busy, (i == 6), (i == 4 || i == 5));
            end
        end
        hw_trig = '0;
        for (int i = 0; i < 6; i++) tick();
        // Activity on an unselected channel must be ignored.
        pulses = 0;
        hw_trig = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 7) hw_trig = '0;
            if (trig_out === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_errors++;
            $display("FAIL hw_unselected_channel: got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_hw_falling();
        int pulses;
        setup(SRC_HW, ACT_FALL, 2'd1, '0, '0, 1'b1);
        pulses = 0;
        hw_trig = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (trig_out === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_errors++;
            $display("FAIL hw_fall_on_rise: got %0d pulses want 0", pulses);
        end
        hw_trig = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (trig_out !== 1'(i == 6)) begin
                n_errors++;
                $display("FAIL hw_fall cycle %0d: got trig=%b want %b", i, trig_out, (i == 6));
            end
        end
    endtask

    task automatic test_debounce();
        int pulses;
        int first;
        setup(SRC_HW, ACT_RISE, 2'd2, '0, 8'd3, 1'b1);
        pulses = 0;
        hw_trig = 4'b0100;
        tick(); tick();
        hw_trig = '0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (trig_out === 1'b1 || busy === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_errors++;
            $display("FAIL debounce_glitch: got %0d active cycles want 0", pulses);
        end
        pulses = 0;
        first = -1;
        hw_trig = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 5) hw_trig = '0;
            if (trig_out === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        n_checks++;
        if (pulses !== 1 || first !== 9) begin
            n_errors++;
            $display("FAIL debounce_pulse: got %0d pulses at cycle %0d want 1 at cycle 9", pulses, first);
        end
    endtask

    task automatic test_sw_back_to_back();
        setup(SRC_SW, ACT_RISE, 2'd0, 24'd10, '0, 1'b1);
        sw_trig = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0) sw_trig = 1'b0;
            if (i == 3) sw_trig = 1'b1;
            if (i == 4) sw_trig = 1'b0;
            n_checks++;
            if (trig_out !== 1'(i == 13)) begin
                n_errors++;
                $display("FAIL sw_delay cycle %0d: got trig=%b want %b", i, trig_out, (i == 13));
            end
        end
        n_checks++;
        if (missed_cnt !== 2'd1) begin
            n_errors++;
            $display("FAIL sw_missed: got %0d want 1", missed_cnt);
        end
    endtask

    task automatic test_immediate();
        setup(SRC_IMM, ACT_RISE, 2'd0, '0, '0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            tick();
            if (i == 5)  sensor_ready = 1'b1;
            if (i == 9)  sensor_ready = 1'b0;
            if (i == 13) sensor_ready = 1'b1;
            n_checks++;
            if (trig_out !== 1'(i == 6 || i == 9 || i == 14 || i == 17)) begin
                n_errors++;
                $display("FAIL imm cycle %0d: got trig=%b want %b", i, trig_out,
                         (i == 6 || i == 9 || i == 14 || i == 17));
            end
        end
        grab_en = 1'b0;
        tick();
        n_checks++;
        if (missed_cnt !== 2'd0) begin
            n_errors++;
            $display("FAIL imm_missed: got %0d want 0", missed_cnt);
        end
    endtask

    task automatic test_abort_and_reset();
        int pulses;
        setup(SRC_SW, ACT_RISE, 2'd0, 24'd100, '0, 1'b1);
        sw_trig = 1'b1;
        tick();
        sw_trig = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_pre_busy: got %b want 1", busy);
        end
        grab_en = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || trig_out !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_idle: got busy=%b trig=%b want 0/0", busy, trig_out);
        end
        pulses = 0;
        for (int i = 0; i < 110; i++) begin
            tick();
            if (trig_out === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_errors++;
            $display("FAIL abort_no_trig: got %0d pulses want 0", pulses);
        end
        setup(SRC_SW, ACT_RISE, 2'd0, '0, '0, 1'b0);
        sw_trig = 1'b1;
        tick();
        sw_trig = 1'b0;
        tick(); tick();
        sw_trig = 1'b1;
        tick();
        sw_trig = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b1 || missed_cnt !== 2'd1) begin
            n_errors++;
            $display("FAIL arm_wait: got busy=%b missed=%0d want 1/1", busy, missed_cnt);
        end
        sys_reset    = 1'b1;
        sensor_ready = 1'b1;
        tick();
        n_checks++;
        if (trig_out !== 1'b0 || busy !== 1'b0 || missed_cnt !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_mid_arm: got trig=%b busy=%b missed=%0d want 0/0/0", trig_out, busy, missed_cnt);
        end
        sys_reset = 1'b0;
        grab_en   = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        setup(SRC_SW, ACT_RISE, 2'd0, 24'd100, '0, 1'b1);
        sw_trig = 1'b1;
        tick();
        sw_trig = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 3) begin
                n_checks++;
                if (missed_cnt !== 2'd1) begin
                    n_errors++;
                    $display("FAIL sat_first: got %0d want 1", missed_cnt);
                end
            end
            sw_trig = ((k % 2) == 1) && (k <= 9);
        end
        n_checks++;
        if (missed_cnt !== 2'd3) begin
            n_errors++;
            $display("FAIL sat_value: got %0d want 3", missed_cnt);
        end
        missed_clr = 1'b1;
        sw_trig    = 1'b1;
        tick();
        n_checks++;
        if (missed_cnt !== 2'd0) begin
            n_errors++;
            $display("FAIL sat_clear: got %0d want 0", missed_cnt);
        end
        sw_trig = 1'b0;
        tick();
        missed_clr = 1'b0;
        tick();
        n_checks++;
        if (missed_cnt !== 2'd0) begin
            n_errors++;
            $display("FAIL clr_priority: got %0d want 0", missed_cnt);
        end
        grab_en = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_hw_rising();
        test_hw_falling();
        test_debounce();
        test_sw_back_to_back();
        test_immediate();
        test_abort_and_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
